// File: rtl/jtsdram_bank_wr.sv
// Paced SDRAM bank filler: writes data_ref to every address 0..LAST_ADDR through a req/ack/rdy port.
// Define JTSDRAM_WR_READBACK_EN to read each word back after writing it and flag mismatches on bad.
module jtsdram_bank_wr #(
   parameter logic [21:0] LAST_ADDR = 22'h3FFFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        LVBL,
   input  logic        slow,
   output logic [21:0] cnt_addr,
   input  logic [21:0] coded_addr,
   input  logic [15:0] data_ref,
   output logic [21:0] sdram_addr,
   output logic [15:0] din,
   output logic        wr,
   output logic        rd,
   input  logic        ack,
   input  logic        rdy,
   input  logic [15:0] data_read,
   output logic        done,
   output logic        bad
);

`ifdef JTSDRAM_WR_READBACK_EN
   typedef enum logic [2:0] {IDLE, GAP, REQ, WAIT_RDY, DONE, DRAIN, RB_REQ, RB_WAIT} state_t;
`else
   typedef enum logic [2:0] {IDLE, GAP, REQ, WAIT_RDY, DONE, DRAIN} state_t;
`endif

   state_t      state;
   logic [15:0] lfsr;
   logic [3:0]  gap;
   logic        lfsr_fb;
   logic        wr_ack;
   logic        wr_fin;
   logic        busy;
   logic        issue;
   logic        restart;
   logic        to_drain;
   logic        step;
`ifdef JTSDRAM_WR_READBACK_EN
   logic        rb_ack;
   logic        rb_fin;
   logic        rb_go;
`else
   logic        unused_data_read;

   assign unused_data_read = ^data_read;
   assign rd  = 1'b0;
   assign bad = 1'b0;
`endif

   assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

   always_comb begin
      wr_ack = (state == REQ) && ack;
      wr_fin = (wr_ack || state == WAIT_RDY) && rdy;
      busy   = wr_ack || (state == WAIT_RDY);
`ifdef JTSDRAM_WR_READBACK_EN
      rb_ack = (state == RB_REQ) && ack;
      rb_fin = (rb_ack || state == RB_WAIT) && rdy;
      busy   = busy || rb_ack || (state == RB_WAIT);
      rb_go  = !start && wr_fin;
      step   = !start && rb_fin;
`else
      step   = !start && wr_fin;
`endif
      issue  = (state == GAP) && !start && (slow ? (gap == 4'd0) : LVBL);
      // A start that lands on an accepted but unfinished request must wait for its rdy first
      to_drain = start && (state != DRAIN) && busy && !rdy;
      restart  = 1'b0;
      if (state == DRAIN)
         restart = rdy;
      else if (start)
         restart = !to_drain;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt_addr   <= '0;
         sdram_addr <= '0;
         din        <= '0;
         wr         <= 1'b0;
         done       <= 1'b0;
         gap        <= '0;
         lfsr       <= 16'hACE1;
`ifdef JTSDRAM_WR_READBACK_EN
         rd         <= 1'b0;
         bad        <= 1'b0;
`endif
      end else begin
         lfsr <= {lfsr[14:0], lfsr_fb};
         if (gap != 4'd0)
            gap <= gap - 4'd1;

         if (restart) begin
            state    <= GAP;
            cnt_addr <= '0;
            done     <= 1'b0;
            wr       <= 1'b0;
            gap      <= lfsr[3:0];
`ifdef JTSDRAM_WR_READBACK_EN
            rd       <= 1'b0;
            bad      <= 1'b0;
`endif
         end else if (to_drain) begin
            state <= DRAIN;
            wr    <= 1'b0;
`ifdef JTSDRAM_WR_READBACK_EN
            rd    <= 1'b0;
`endif
         end else if (issue) begin
            state      <= REQ;
            sdram_addr <= coded_addr;
            din        <= data_ref;
            wr         <= 1'b1;
`ifdef JTSDRAM_WR_READBACK_EN
         end else if (rb_go) begin
            state <= RB_REQ;
            wr    <= 1'b0;
            rd    <= 1'b1;
`endif
         end else if (step) begin
            wr <= 1'b0;
`ifdef JTSDRAM_WR_READBACK_EN
            rd <= 1'b0;
            if (data_read != din)
               bad <= 1'b1;
`endif
            // The last address ends the fill; the counter never wraps
            if (cnt_addr == LAST_ADDR) begin
               state <= DONE;
               done  <= 1'b1;
            end else begin
               state    <= GAP;
               cnt_addr <= cnt_addr + 22'd1;
               gap      <= lfsr[3:0];
            end
         end else if (wr_ack) begin
            state <= WAIT_RDY;
            wr    <= 1'b0;
`ifdef JTSDRAM_WR_READBACK_EN
         end else if (rb_ack) begin
            state <= RB_WAIT;
            rd    <= 1'b0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_jtsdram_bank_wr.sv
// Directed bench for jtsdram_bank_wr with a shortened bank (LAST_ADDR=0x1F) and a
// req/ack/rdy controller model; readback cases build only with JTSDRAM_WR_READBACK_EN.
module tb_jtsdram_bank_wr;
   localparam logic [21:0] LAST = 22'h00001F;

   logic        clk, rst_n, start, LVBL, slow;
   logic [21:0] cnt_addr, coded_addr, sdram_addr;
   logic [15:0] data_ref, din, data_read;
   logic        wr, rd, ack, rdy, done, bad;

   int          n_chk = 0, n_err = 0;
   int          ack_dly = 2, rdy_dly = 5;
   bit          same = 0, rdy_pend = 0;
   int          n_rd = 0, bad_at = -1;
   logic [21:0] wq_a[$];
   logic [15:0] wq_d[$];
   logic [15:0] mem[logic [21:0]];
   logic        c_wr, c_live;
   logic [21:0] c_a;
   logic [15:0] tb_lfsr;
   int          t, cyc, nwr;
   logic [3:0]  g;

   function automatic logic [21:0] code_f(input logic [21:0] a);
      return {a[10:0], a[21:11]} ^ 22'h2A5A5A;
   endfunction

   function automatic logic [15:0] data_f(input logic [21:0] a);
      return a[15:0] ^ 16'hC3A5;
   endfunction

   // Memory model flips bit 0 of the word stored at linear address 0x10
   function automatic logic [15:0] rd_val(input logic [21:0] a);
      logic [15:0] v;
      v = mem.exists(a) ? mem[a] : 16'h0000;
      if (a == code_f(22'h000010)) v = v ^ 16'h0001;
      return v;
   endfunction

   assign coded_addr = code_f(cnt_addr);
   assign data_ref   = data_f(cnt_addr);

   jtsdram_bank_wr #(.LAST_ADDR(LAST)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .LVBL(LVBL), .slow(slow),
      .cnt_addr(cnt_addr), .coded_addr(coded_addr), .data_ref(data_ref),
      .sdram_addr(sdram_addr), .din(din), .wr(wr), .rd(rd), .ack(ack), .rdy(rdy),
      .data_read(data_read), .done(done), .bad(bad)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n)
      if (!rst_n) tb_lfsr <= 16'hACE1;
      else        tb_lfsr <= {tb_lfsr[14:0], tb_lfsr[15] ^ tb_lfsr[13] ^ tb_lfsr[12] ^ tb_lfsr[10]};

   // SDRAM controller model: ack after ack_dly cycles, rdy rdy_dly cycles after ack (or together)
   initial begin
      ack = 1'b0; rdy = 1'b0; data_read = 16'hFFFF;
      forever begin
         @(negedge clk);
         if (rst_n && (wr || rd)) begin
            c_wr = wr; c_a = sdram_addr; c_live = 1'b1;
            for (int i = 0; i < ack_dly; i++) begin
               @(negedge clk);
               if (!(wr || rd)) begin c_live = 1'b0; break; end
            end
            if (c_live) begin
               ack = 1'b1;
               if (c_wr) begin
                  wq_a.push_back(c_a); wq_d.push_back(din); mem[c_a] = din;
               end else n_rd++;
               if (same) begin rdy = 1'b1; data_read = rd_val(c_a); end
               @(negedge clk);
               ack = 1'b0; rdy = 1'b0;
               if (!same) begin
                  rdy_pend = 1'b1;
                  repeat (rdy_dly - 1) @(negedge clk);
                  rdy = 1'b1; data_read = rd_val(c_a);
                  @(negedge clk);
                  rdy = 1'b0; rdy_pend = 1'b0;
               end
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk); #1 start = 1'b1;
      @(negedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      t = 0;
      while (!done && t < bound) begin
         @(negedge clk); #1 t++;
         if (bad && bad_at < 0) bad_at = int'(cnt_addr);
      end
      chk("fill_done", done, 1);
   endtask

   task automatic check_fill();
      chk("n_writes", wq_a.size(), 32'(LAST) + 1);
      for (int i = 0; i < wq_a.size() && i <= int'(LAST); i++) begin
         chk("wr_addr", wq_a[i], code_f(i[21:0]));
         chk("wr_data", wq_d[i], data_f(i[21:0]));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; LVBL = 1'b0; slow = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_wr", wr, 0); chk("rst_rd", rd, 0); chk("rst_done", done, 0);
      chk("rst_bad", bad, 0); chk("rst_cnt", cnt_addr, 0);
      chk("rst_saddr", sdram_addr, 0); chk("rst_din", din, 0);
      rst_n = 1'b1;
      nwr = 0;
      repeat (10) begin @(negedge clk); #1 if (wr) nwr++; end
      chk("idle_no_wr", nwr, 0);

      // LVBL pacing: no write while LVBL is low
      pulse_start();
      nwr = 0;
      repeat (100) begin @(negedge clk); #1 if (wr) nwr++; end
      chk("lvbl_hold", nwr, 0);
      LVBL = 1'b1;
      t = 0;
      while (!wr && t < 20) begin @(negedge clk); #1 t++; end
      chk("first_wr", wr, 1);
      chk("first_addr", sdram_addr, code_f(22'd0));
      chk("first_din", din, data_f(22'd0));
      wait_done(5000);
      check_fill();
      repeat (20) @(negedge clk);
      #1;
      chk("done_hold", done, 1); chk("idle_wr", wr, 0); chk("last_cnt", cnt_addr, LAST);
`ifndef JTSDRAM_WR_READBACK_EN
      chk("rd_tied", n_rd, 0); chk("bad_tied", bad, 0);
`endif

      // Random-gap pacing from DONE: first write after lfsr[3:0]+2 negedges, LVBL ignored
      slow = 1'b1; LVBL = 1'b0;
      wq_a.delete(); wq_d.delete();
      @(negedge clk); #1;
      g = tb_lfsr[3:0];
      start = 1'b1;
      @(negedge clk); #1 start = 1'b0;
      cyc = 1;
      chk("restart_done", done, 0);
      while (!wr && cyc < 40) begin @(negedge clk); #1 cyc++; end
      chk("gap_latency", cyc, 32'(g) + 2);
      wait_done(8000);
      check_fill();

      // Ack and rdy together on every request
      slow = 1'b0; LVBL = 1'b1; same = 1'b1;
      wq_a.delete(); wq_d.delete();
      pulse_start();
      wait_done(5000);
      check_fill();
      same = 1'b0;

      // Start while waiting for rdy at cnt_addr 5 drains, then refills from 0
      rdy_dly = 30;
      wq_a.delete(); wq_d.delete();
      pulse_start();
      t = 0;
      while (wq_a.size() < 6 && t < 2000) begin @(negedge clk); #1 t++; end
      @(negedge clk); #1;
      chk("drain_cnt5", cnt_addr, 5);
      start = 1'b1;
      @(negedge clk); #1 start = 1'b0;
      rdy_dly = 5;
      chk("drain_hold_cnt", cnt_addr, 5);
      wq_a.delete(); wq_d.delete();
      nwr = 0; t = 0;
      while (rdy_pend && t < 100) begin @(negedge clk); #1 t++; if (wr) nwr++; end
      chk("drain_no_wr", nwr, 0);
      chk("drain_restart_cnt", cnt_addr, 0);
      wait_done(5000);
      check_fill();

      // Asynchronous reset in the middle of a write request
      wq_a.delete(); wq_d.delete();
      pulse_start();
      t = 0;
      while (wq_a.size() < 3 && t < 2000) begin @(negedge clk); #1 t++; end
      t = 0;
      while (!wr && t < 50) begin @(negedge clk); #1 t++; end
      chk("pre_rst_wr", wr, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_wr", wr, 0); chk("arst_done", done, 0); chk("arst_cnt", cnt_addr, 0);
      @(negedge clk); rst_n = 1'b1;
      nwr = 0;
      repeat (20) begin @(negedge clk); #1 if (wr) nwr++; end
      chk("post_rst_idle", nwr, 0);
      chk("post_rst_cnt", cnt_addr, 0);
      wq_a.delete(); wq_d.delete();
      pulse_start();
      wait_done(5000);
      check_fill();

`ifdef JTSDRAM_WR_READBACK_EN
      // Readback: the corrupted word at 0x10 sets bad as the counter steps to 0x11
      wq_a.delete(); wq_d.delete(); n_rd = 0; bad_at = -1;
      pulse_start();
      wait_done(8000);
      check_fill();
      chk("rb_reads", n_rd, 32'(LAST) + 1);
      chk("bad_sticky", bad, 1);
      chk("bad_at", bad_at, 32'h11);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/jtsdram_bank_wr.md
JTSDRAM_BANK_WR -- requirements
Module: jtsdram_bank_wr

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have port: start  input  1  one-cycle pulse; (re)starts the fill from address 0.
REQ-004 SHALL have port: LVBL  input  1  vertical blank, active-low; paces writes when slow=0.
REQ-005 SHALL have port: slow  input  1  1 = pseudo-random gap pacing; 0 = LVBL pacing.
REQ-006 SHALL have port: cnt_addr  output  22  linear write address, to external address coder.
REQ-007 SHALL have port: coded_addr  input  22  coded form of cnt_addr, same cycle.
REQ-008 SHALL have port: data_ref  input  16  write pattern for cnt_addr, same cycle.
REQ-009 SHALL have port: sdram_addr  output  22  request address to SDRAM controller.
REQ-010 SHALL have port: din  output  16  write data to SDRAM controller.
REQ-011 SHALL have port: wr  output  1  write request.
REQ-012 SHALL have port: rd  output  1  read request (readback only).
REQ-013 SHALL have port: ack  input  1  controller accepted current request.
REQ-014 SHALL have port: rdy  input  1  controller finished current request.
REQ-015 SHALL have port: data_read  input  16  readback data, valid with rdy.
REQ-016 SHALL have ports: done, bad  output  1 each  fill complete; sticky readback mismatch.

Function
REQ-017 SHALL implement states IDLE, GAP, REQ, WAIT_RDY, DONE, DRAIN; plus RB_REQ, RB_WAIT when readback compiled in.
REQ-018 SHALL leave IDLE only on start: cnt_addr<=0, done<=0, bad<=0, enter GAP.
REQ-019 SHALL, in GAP with slow=0, enter REQ on first cycle LVBL=1.
REQ-020 SHALL, in GAP with slow=1, wait until internal 4-bit gap counter reaches 0, then enter REQ.
REQ-021 SHALL load the gap counter with lfsr[3:0] on every GAP entry; counter decrements once per cycle, saturating at 0.
REQ-022 SHALL use a free-running 16-bit Fibonacci LFSR, taps 16,14,13,11, reset seed 16'hACE1, advancing every cycle.
REQ-023 SHALL, on REQ entry, latch sdram_addr<=coded_addr, din<=data_ref and assert wr; sdram_addr/din stay stable until the request's rdy.
REQ-024 SHALL hold wr high until ack; wr low the cycle after ack sampled; then enter WAIT_RDY.
REQ-025 SHALL, on rdy in WAIT_RDY (readback off): if cnt_addr==22'h3FFFFF enter DONE with done<=1; else cnt_addr<=cnt_addr+1, enter GAP.
REQ-026 SHALL never wrap cnt_addr; all-ones is the last address written.
REQ-027 SHALL ignore rdy outside WAIT_RDY/RB_WAIT/DRAIN and ack outside REQ/RB_REQ.
REQ-028 SHALL hold done=1 in DONE until the next start.
REQ-029 SHALL, on start in GAP, REQ (before ack), or DONE: drop wr/rd next cycle and restart per REQ-018.
REQ-030 SHALL, on start in WAIT_RDY/RB_WAIT, or in REQ/RB_REQ same cycle as ack: enter DRAIN, wait rdy, then restart per REQ-018.
REQ-031 SHALL accept ack and rdy in the same cycle as one complete transaction.

Reset
REQ-032 SHALL, while rst_n=0: state IDLE; cnt_addr, sdram_addr, din=0; wr, rd, done, bad=0; gap counter 0; LFSR 16'hACE1.
REQ-033 SHALL, on reset mid-transfer, drop wr/rd immediately; no drain.

Configuration
REQ-034 SHALL compile readback in only when JTSDRAM_WR_READBACK_EN is defined.
REQ-035 SHALL, with JTSDRAM_WR_READBACK_EN: write rdy -> RB_REQ; assert rd, same sdram_addr, until ack; then RB_WAIT; on rdy set bad<=1 if data_read!=din; then apply REQ-025 address/done step.
REQ-036 SHALL, without JTSDRAM_WR_READBACK_EN: rd and bad tied 0; data_read ignored.

Verification
REQ-037 SHALL test: slow=0, LVBL low 100 cycles then high, start -> no wr until LVBL=1; first write sdram_addr=coded_addr(0), din=data_ref(0).
REQ-038 SHALL test: slow=1, controller ack +2 cycles, rdy +5 cycles, full fill -> 4194304 writes, addresses 0..3FFFFF in order, done=1 after last rdy, wr idle after.
REQ-039 SHALL test: start while in WAIT_RDY at cnt_addr=5 -> DRAIN, no new wr until rdy, then restart with cnt_addr=0.
REQ-040 SHALL test: ack and rdy in the same cycle at every request -> one write per address, no duplicates.
REQ-041 SHALL test: readback on, memory model corrupts address 22'h000010 -> bad=1 after that readback, remains 1, fill still completes with done=1.
REQ-042 SHALL test: rst_n low for 1 cycle mid-write -> wr=0, done=0, cnt_addr=0 asynchronously; no activity until start.
